// File: rtl/embed_loader_pkg.sv
// Shared state encodings, bus constants and sizing helper for the SPI embed loader.
package embed_loader_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_WE    = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_BUS   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_RDOUT = 3'd6;

    localparam logic [1:0] SEL_ALL = 2'b11;

    // Bit counter must index the longer of the two serial fields.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises spi_clk/spi_mosi into clk and flags synced rising edges of spi_clk.
// Latency SYNC_STAGES cycles to sclk_rise; no backpressure, the serial master free-runs.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   clk_prev;

    // mosi idles high, so its chain resets to 1 to keep a stray edge from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            mosi_sync <= '1;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign mosi      = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_embed_loader.sv
// Serial slave turning each SPI frame into one Wishbone single transfer; miso=1 while busy.
// miso follows a synced sclk rise by 1 cycle; the bus waits on ack/err up to TIMEOUT cycles.
module spi_embed_loader
    import embed_loader_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [DATA_W-1:0] o_wb_o_dat,
    output logic [1:0]        o_wb_sel,
    input  logic [DATA_W-1:0] i_wb_i_dat,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    output logic              o_err
);

    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic              sclk_rise;
    logic              mosi;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] wdat_sr;
    logic [DATA_W-1:0] rdat_sr;
    logic              we_r;
    logic              bus_act;
    logic              miso_r;
    logic              err_r;
    logic              tmo_hit;
    logic              bus_end;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (i_clk),
        .rst       (i_rst),
        .spi_clk   (i_spi_clk),
        .spi_mosi  (i_spi_mosi),
        .sclk_rise (sclk_rise),
        .mosi      (mosi)
    );

    // BUS cycles are counted from 0, so the last permitted one holds TIMEOUT-1.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign bus_end = i_wb_ack | i_wb_err | tmo_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tmo_cnt <= '0;
            addr_sr <= '0;
            wdat_sr <= '0;
            rdat_sr <= '0;
            we_r    <= 1'b0;
            bus_act <= 1'b0;
            miso_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (!i_enable) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tmo_cnt <= '0;
            bus_act <= 1'b0;
            miso_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sclk_rise && !mosi) begin
                        state  <= ST_ADDR;
                        cnt    <= '0;
                        miso_r <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_sr <= {mosi, addr_sr[ADDR_W-1:1]};
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            state <= ST_WE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_WE: begin
                    if (sclk_rise) begin
                        we_r <= mosi;
                        cnt  <= '0;
                        if (mosi) begin
                            state <= ST_DATA;
                        end else begin
                            state   <= ST_BUS;
                            bus_act <= 1'b1;
                            tmo_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        wdat_sr <= {mosi, wdat_sr[DATA_W-1:1]};
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state   <= ST_BUS;
                            cnt     <= '0;
                            bus_act <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    // Serial edges arriving here are dropped on purpose.
                    if (bus_end) begin
                        state   <= ST_DONE;
                        cnt     <= '0;
                        tmo_cnt <= '0;
                        bus_act <= 1'b0;
                        miso_r  <= 1'b0;
                        rdat_sr <= (i_wb_ack && !i_wb_err && !tmo_hit) ? i_wb_i_dat : '0;
                        if (i_wb_err || (tmo_hit && !i_wb_ack)) begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (sclk_rise) begin
                        cnt <= '0;
                        if (we_r) begin
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_RDOUT;
                            miso_r <= rdat_sr[0];
                        end
                    end
                end
                ST_RDOUT: begin
                    if (sclk_rise) begin
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            miso_r <= 1'b0;
                        end else begin
                            rdat_sr <= {1'b0, rdat_sr[DATA_W-1:1]};
                            miso_r  <= rdat_sr[1];
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    bus_act <= 1'b0;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_spi_miso = miso_r;
    assign o_wb_cyc   = bus_act;
    assign o_wb_stb   = bus_act;
    assign o_wb_we    = we_r;
    assign o_wb_adr   = addr_sr;
    assign o_wb_o_dat = wdat_sr;
    assign o_wb_sel   = bus_act ? SEL_ALL : 2'b00;
    assign o_err      = err_r;

endmodule

// File: tb/tb_spi_embed_loader.sv
// Directed bench for spi_embed_loader: vector table of frames plus abort/back-to-back sequences.
module tb_spi_embed_loader;

    logic        clk;
    logic        i_rst;
    logic        i_enable;
    logic        i_spi_clk;
    logic        i_spi_mosi;
    logic        o_spi_miso;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [23:0] o_wb_adr;
    logic [15:0] o_wb_o_dat;
    logic [1:0]  o_wb_sel;
    logic [15:0] i_wb_i_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    spi_embed_loader #(
        .ADDR_W(24), .DATA_W(16), .SYNC_STAGES(2), .TIMEOUT(255)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_spi_clk  (i_spi_clk),
        .i_spi_mosi (i_spi_mosi),
        .o_spi_miso (o_spi_miso),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_adr   (o_wb_adr),
        .o_wb_o_dat (o_wb_o_dat),
        .o_wb_sel   (o_wb_sel),
        .i_wb_i_dat (i_wb_i_dat),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Slave configuration: mode 0 silent, 1 ack, 2 err; response after slv_lat cycles of cyc.
    int slv_mode = 1;
    int slv_lat  = 0;

    // Monitor/slave state, written only by the negedge process below.
    int          n_bus_start = 0;
    int          n_bus_end   = 0;
    int          cur_len     = 0;
    int          last_len    = 0;
    int          miso_bad    = 0;
    int          wait_cnt    = 0;
    logic        resp_done   = 1'b0;
    logic        cyc_prev    = 1'b0;
    logic        post_miso   = 1'b0;
    logic [23:0] cap_adr     = '0;
    logic [15:0] cap_dat     = '0;
    logic        cap_we      = 1'b0;
    logic [1:0]  cap_sel     = '0;

    always @(negedge clk) begin
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (o_wb_cyc && !cyc_prev) begin
            n_bus_start = n_bus_start + 1;
            cur_len  = 0;
            miso_bad = 0;
            cap_adr  = o_wb_adr;
            cap_dat  = o_wb_o_dat;
            cap_we   = o_wb_we;
            cap_sel  = o_wb_sel;
        end
        if (!o_wb_cyc && cyc_prev) begin
            last_len  = cur_len;
            post_miso = o_spi_miso;
            n_bus_end = n_bus_end + 1;
        end
        if (o_wb_cyc && o_wb_stb) begin
            cur_len = cur_len + 1;
            if (!o_spi_miso) miso_bad = miso_bad + 1;
            if (!resp_done && wait_cnt == slv_lat && slv_mode != 0) begin
                if (slv_mode == 1) i_wb_ack = 1'b1;
                else               i_wb_err = 1'b1;
                resp_done = 1'b1;
            end
            wait_cnt = wait_cnt + 1;
        end else begin
            wait_cnt  = 0;
            resp_done = 1'b0;
        end
        cyc_prev = o_wb_cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk);
        i_spi_mosi = b;
        i_spi_clk  = 1'b0;
        repeat (4) @(negedge clk);
        i_spi_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_idle();
        @(negedge clk);
        i_spi_clk  = 1'b0;
        i_spi_mosi = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        spi_idle();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] a, input logic w, input logic [15:0] d);
        spi_bit(1'b0);
        for (int i = 0; i < 24; i++) spi_bit(a[i]);
        spi_bit(w);
        if (w) for (int i = 0; i < 16; i++) spi_bit(d[i]);
    endtask

    // One complete transaction: frame, bus, acknowledge clock and (for reads) the readout.
    task automatic do_frame(input logic [23:0] a, input logic w, input logic [15:0] d,
                            input int mode, input int lat, input logic [15:0] rdat,
                            input int exp_len, input logic exp_err, input logic [15:0] exp_rd);
        int          snap;
        logic [15:0] word;
        slv_mode   = mode;
        slv_lat    = lat;
        i_wb_i_dat = rdat;
        snap = n_bus_end;
        send_frame(a, w, d);
        for (int k = 0; k < 2000 && n_bus_end == snap; k++) @(negedge clk);
        chk("bus_done", 32'(n_bus_end != snap), 32'd1);
        chk("adr", 32'(cap_adr), 32'(a));
        chk("we", 32'(cap_we), 32'(w));
        chk("sel", 32'(cap_sel), 32'd3);
        if (w) chk("wdat", 32'(cap_dat), 32'(d));
        chk("cyc_len", 32'(last_len), 32'(exp_len));
        chk("miso_busy_low", 32'(miso_bad), 32'd0);
        chk("miso_ready", 32'(post_miso), 32'd0);
        chk("o_err", 32'(o_err), 32'(exp_err));
        spi_bit(1'b1);
        if (w) begin
            chk("wr_ack_miso", 32'(o_spi_miso), 32'd0);
        end else begin
            word = '0;
            word[0] = o_spi_miso;
            for (int i = 1; i < 16; i++) begin
                spi_bit(1'b1);
                word[i] = o_spi_miso;
            end
            chk("rdout", 32'(word), 32'(exp_rd));
            spi_bit(1'b1);
            chk("rd_end_miso", 32'(o_spi_miso), 32'd0);
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [15:0] wdat;
        int          mode;
        int          lat;
        logic [15:0] rdat;
        int          exp_len;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic        pre_rst;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s0;
        vecs[0] = '{24'h800020, 1'b1, 16'h3888, 1, 0, 16'h0000,   1, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{24'h800003, 1'b0, 16'h0000, 1, 2, 16'h0001,   3, 1'b0, 16'h0001, 1'b0};
        vecs[2] = '{24'h123456, 1'b1, 16'hA5C3, 1, 1, 16'h0000,   2, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{24'hFFFFFF, 1'b0, 16'h0000, 1, 0, 16'hBEEF,   1, 1'b0, 16'hBEEF, 1'b0};
        vecs[4] = '{24'h000001, 1'b0, 16'h0000, 0, 0, 16'h1234, 255, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{24'h800010, 1'b1, 16'h5555, 2, 1, 16'h0000,   2, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{24'h7FFFFE, 1'b0, 16'h0000, 2, 3, 16'h4321,   4, 1'b1, 16'h0000, 1'b1};

        i_rst      = 1'b1;
        i_enable   = 1'b1;
        i_spi_clk  = 1'b0;
        i_spi_mosi = 1'b1;
        i_wb_i_dat = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        chk("rst_miso", 32'(o_spi_miso), 32'd0);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(o_wb_stb), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_adr", 32'(o_wb_adr), 32'd0);
        chk("rst_dat", 32'(o_wb_o_dat), 32'd0);
        chk("rst_sel", 32'(o_wb_sel), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        // Idle clocks with mosi high must not start a frame.
        s0 = n_bus_start;
        for (int i = 0; i < 8; i++) spi_bit(1'b1);
        chk("idle_bus", 32'(n_bus_start - s0), 32'd0);
        chk("idle_miso", 32'(o_spi_miso), 32'd0);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].pre_rst) pulse_reset();
            do_frame(vecs[v].addr, vecs[v].we, vecs[v].wdat, vecs[v].mode, vecs[v].lat,
                     vecs[v].rdat, vecs[v].exp_len, vecs[v].exp_err, vecs[v].exp_rd);
        end

        // Back-to-back writes with ascending addresses.
        pulse_reset();
        s0 = n_bus_start;
        for (int i = 0; i < 4; i++)
            do_frame(24'h80003a + 24'(i), 1'b1, 16'h0000, 1, 0, 16'h0000, 1, 1'b0, 16'h0000);
        chk("b2b_count", 32'(n_bus_start - s0), 32'd4);

        // Aborts: a[0] selects reset vs enable, a[1] selects mid-ADDR vs mid-BUS.
        for (int a = 0; a < 4; a++) begin
            pulse_reset();
            if (a >= 2) begin
                slv_mode = 0;
                send_frame(24'h800040, 1'b1, 16'h1234);
                spi_idle();
                chk("abort_pre_cyc", 32'(o_wb_cyc), 32'd1);
            end else begin
                spi_bit(1'b0);
                for (int i = 0; i < 5; i++) spi_bit(1'b1);
                spi_idle();
                chk("abort_pre_miso", 32'(o_spi_miso), 32'd1);
            end
            @(negedge clk);
            if (a % 2 == 0) i_rst = 1'b1;
            else            i_enable = 1'b0;
            @(negedge clk);
            chk("abort_cyc", 32'(o_wb_cyc), 32'd0);
            chk("abort_miso", 32'(o_spi_miso), 32'd0);
            i_rst    = 1'b0;
            i_enable = 1'b1;
            @(negedge clk);
            do_frame(24'h800050 + 24'(a), 1'b1, 16'hC0DE, 1, 0, 16'h0000, 1, 1'b0, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
